// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU/M-extension opcodes, result
// selects, forwarding sources and divider FSM states.
package ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_LINK = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Loads sitting in EX/MEM have no data yet, so they never match here.
    function automatic fwd_sel_e fwd_select(
        input logic       en,
        input logic [4:0] rs,
        input logic       ex_we,
        input logic [4:0] ex_rd,
        input logic [1:0] ex_src,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        fwd_sel_e sel;
        sel = FWD_NONE;
        if (en && ex_we && (ex_rd != 5'd0) && (ex_rd == rs) && (ex_src != RES_MEM))
            sel = FWD_EXMEM;
        else if (en && wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            sel = FWD_MEMWB;
        return sel;
    endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Unsigned restoring divider core: one quotient bit per cycle, XLEN steps,
// done pulses combinationally during the final step.
module ex_stage_div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int unsigned CW = $clog2(XLEN);

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN:0]   partial;

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        partial = {rem_q, quot_q[XLEN-1]};
        done    = busy_q && (cnt_q == CW'(XLEN-1)) && !abort;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quot_d = dividend;
            rem_d  = '0;
            dvsr_d = divisor;
        end else if (busy_q) begin
            if (partial >= {1'b0, dvsr_q}) begin
                rem_d  = XLEN'(partial - {1'b0, dvsr_q});
                quot_d = {quot_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d  = partial[XLEN-1:0];
                quot_d = {quot_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1))
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, single-cycle multiply, iterative
// divide with front-end stall, and the EX/MEM pipeline register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned XLEN   = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic [XLEN-1:0] id_ex_pc,
    input  logic [XLEN-1:0] id_ex_rs1_val,
    input  logic [XLEN-1:0] id_ex_rs2_val,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [4:0]      id_ex_rs1,
    input  logic [4:0]      id_ex_rs2,
    input  logic [4:0]      id_ex_rd,
    input  logic [3:0]      id_ex_ALUControl,
    input  logic            id_ex_ALUSrc,
    input  logic            id_ex_MulDiv,
    input  logic [2:0]      id_ex_MulDivOp,
    input  logic            id_ex_RegWrite,
    input  logic            id_ex_MemRead,
    input  logic            id_ex_MemWrite,
    input  logic [1:0]      id_ex_ResultSrc,
    input  logic [4:0]      wb_rd,
    input  logic            wb_RegWrite,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_busy,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [XLEN-1:0] ex_mem_store_val,
    output logic [XLEN-1:0] ex_mem_link_val,
    output logic [4:0]      ex_mem_rd,
    output logic            ex_mem_RegWrite,
    output logic            ex_mem_MemRead,
    output logic            ex_mem_MemWrite,
    output logic [1:0]      ex_mem_ResultSrc
);
    div_state_e      state_q, state_d;
    logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;
    logic [XLEN-1:0] alu_res_q, alu_res_d, store_q, store_d, link_q, link_d;
    logic [4:0]      rd_q, rd_d;
    logic            regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
    logic [1:0]      res_src_q, res_src_d;

    logic [XLEN-1:0]   rs1_fwd, rs2_fwd, op_b, exmem_fwd_val, alu_out, mul_out, div_out;
    logic [XLEN-1:0]   div_a, div_b, div_quot, div_rem;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic              is_div, signed_div, a_neg, b_neg, busy, div_start, div_abort, div_done;
    fwd_sel_e          sel_a, sel_b;

    always_comb begin
        exmem_fwd_val = (res_src_q == RES_LINK) ? link_q : alu_res_q;
        sel_a = fwd_select(FWD_EN, id_ex_rs1, regwrite_q, rd_q, res_src_q, wb_RegWrite, wb_rd);
        sel_b = fwd_select(FWD_EN, id_ex_rs2, regwrite_q, rd_q, res_src_q, wb_RegWrite, wb_rd);
        case (sel_a)
            FWD_EXMEM: rs1_fwd = exmem_fwd_val;
            FWD_MEMWB: rs1_fwd = wb_result;
            default:   rs1_fwd = id_ex_rs1_val;
        endcase
        case (sel_b)
            FWD_EXMEM: rs2_fwd = exmem_fwd_val;
            FWD_MEMWB: rs2_fwd = wb_result;
            default:   rs2_fwd = id_ex_rs2_val;
        endcase
        op_b = id_ex_ALUSrc ? id_ex_imm : rs2_fwd;
    end

    always_comb begin
        case (alu_op_e'(id_ex_ALUControl))
            ALU_ADD:   alu_out = rs1_fwd + op_b;
            ALU_SUB:   alu_out = rs1_fwd - op_b;
            ALU_AND:   alu_out = rs1_fwd & op_b;
            ALU_OR:    alu_out = rs1_fwd | op_b;
            ALU_XOR:   alu_out = rs1_fwd ^ op_b;
            ALU_SLL:   alu_out = rs1_fwd << op_b[4:0];
            ALU_SRL:   alu_out = rs1_fwd >> op_b[4:0];
            ALU_SRA:   alu_out = XLEN'($signed(rs1_fwd) >>> op_b[4:0]);
            ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1_fwd) < $signed(op_b))};
            ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (rs1_fwd < op_b)};
            ALU_PASSB: alu_out = op_b;
            default:   alu_out = '0;
        endcase
    end

    // One 2*XLEN multiplier; operands are sign- or zero-extended per op.
    always_comb begin
        mul_a   = {{XLEN{((id_ex_MulDivOp == MD_MULH) || (id_ex_MulDivOp == MD_MULHSU))
                          && rs1_fwd[XLEN-1]}}, rs1_fwd};
        mul_b   = {{XLEN{(id_ex_MulDivOp == MD_MULH) && rs2_fwd[XLEN-1]}}, rs2_fwd};
        prod    = mul_a * mul_b;
        mul_out = (id_ex_MulDivOp == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        is_div     = id_ex_MulDiv && id_ex_MulDivOp[2];
        signed_div = !id_ex_MulDivOp[0];
        a_neg      = signed_div && rs1_fwd[XLEN-1];
        b_neg      = signed_div && rs2_fwd[XLEN-1];
        div_a      = a_neg ? -rs1_fwd : rs1_fwd;
        div_b      = b_neg ? -rs2_fwd : rs2_fwd;
        if (id_ex_MulDivOp[1])
            div_out = r_neg_q ? -div_rem : div_rem;
        else if (div0_q)
            div_out = '1;
        else
            div_out = q_neg_q ? -div_quot : div_quot;
    end

    ex_stage_div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .abort     (div_abort),
        .dividend  (div_a),
        .divisor   (div_b),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        div0_d    = div0_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        busy      = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (is_div && !flush) begin
                    div_start = 1'b1;
                    busy      = 1'b1;
                    q_neg_d   = a_neg ^ b_neg;
                    r_neg_d   = a_neg;
                    div0_d    = (rs2_fwd == '0);
                    state_d   = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (flush) begin
                    div_abort = 1'b1;
                    state_d   = DIV_IDLE;
                end else begin
                    busy = 1'b1;
                    if (div_done)
                        state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                div_abort = flush;
                state_d   = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // Bubbles clear only the controls and rd; data fields keep their last value.
    always_comb begin
        alu_res_d  = alu_res_q;
        store_d    = store_q;
        link_d     = link_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        res_src_d  = res_src_q;
        if (flush || busy) begin
            rd_d       = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else begin
            rd_d       = id_ex_rd;
            regwrite_d = id_ex_RegWrite;
            memread_d  = id_ex_MemRead;
            memwrite_d = id_ex_MemWrite;
            res_src_d  = id_ex_ResultSrc;
            store_d    = rs2_fwd;
            link_d     = id_ex_pc + XLEN'(4);
            if (state_q == DIV_DONE)
                alu_res_d = div_out;
            else
                alu_res_d = id_ex_MulDiv ? mul_out : alu_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= DIV_IDLE;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div0_q     <= 1'b0;
            alu_res_q  <= '0;
            store_q    <= '0;
            link_q     <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            res_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div0_q     <= div0_d;
            alu_res_q  <= alu_res_d;
            store_q    <= store_d;
            link_q     <= link_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            res_src_q  <= res_src_d;
        end
    end

    assign ex_busy           = reset_n && busy;
    assign ex_mem_alu_result = alu_res_q;
    assign ex_mem_store_val  = store_q;
    assign ex_mem_link_val   = link_q;
    assign ex_mem_rd         = rd_q;
    assign ex_mem_RegWrite   = regwrite_q;
    assign ex_mem_MemRead    = memread_q;
    assign ex_mem_MemWrite   = memwrite_q;
    assign ex_mem_ResultSrc  = res_src_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU, multiply, divide timing and
// special cases, flush and asynchronous reset during a divide.
module tb_ex_stage;

    logic        clk, reset_n, flush;
    logic [31:0] id_ex_pc, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [3:0]  id_ex_ALUControl;
    logic        id_ex_ALUSrc, id_ex_MulDiv;
    logic [2:0]  id_ex_MulDivOp;
    logic        id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite;
    logic [1:0]  id_ex_ResultSrc;
    logic [4:0]  wb_rd;
    logic        wb_RegWrite;
    logic [31:0] wb_result;
    logic        ex_busy;
    logic [31:0] ex_mem_alu_result, ex_mem_store_val, ex_mem_link_val;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite;
    logic [1:0]  ex_mem_ResultSrc;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_pc   = 32'h0000_1000;

    ex_stage #(.FWD_EN(1'b1), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .id_ex_pc(id_ex_pc), .id_ex_rs1_val(id_ex_rs1_val), .id_ex_rs2_val(id_ex_rs2_val),
        .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_ALUControl(id_ex_ALUControl), .id_ex_ALUSrc(id_ex_ALUSrc),
        .id_ex_MulDiv(id_ex_MulDiv), .id_ex_MulDivOp(id_ex_MulDivOp),
        .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead),
        .id_ex_MemWrite(id_ex_MemWrite), .id_ex_ResultSrc(id_ex_ResultSrc),
        .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite), .wb_result(wb_result),
        .ex_busy(ex_busy), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_store_val(ex_mem_store_val), .ex_mem_link_val(ex_mem_link_val),
        .ex_mem_rd(ex_mem_rd), .ex_mem_RegWrite(ex_mem_RegWrite),
        .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
        .ex_mem_ResultSrc(ex_mem_ResultSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        id_ex_pc = '0; id_ex_rs1_val = '0; id_ex_rs2_val = '0; id_ex_imm = '0;
        id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
        id_ex_ALUControl = '0; id_ex_ALUSrc = 1'b0; id_ex_MulDiv = 1'b0; id_ex_MulDivOp = '0;
        id_ex_RegWrite = 1'b0; id_ex_MemRead = 1'b0; id_ex_MemWrite = 1'b0; id_ex_ResultSrc = '0;
    endtask

    task automatic set_instr(input logic [3:0] aluc, input logic md, input logic [2:0] mdop,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] v1, input logic [31:0] v2,
                             input logic [31:0] imm, input logic alusrc);
        cur_pc = cur_pc + 32'd4;
        id_ex_pc = cur_pc; id_ex_rs1_val = v1; id_ex_rs2_val = v2; id_ex_imm = imm;
        id_ex_rs1 = rs1; id_ex_rs2 = rs2; id_ex_rd = rd;
        id_ex_ALUControl = aluc; id_ex_ALUSrc = alusrc; id_ex_MulDiv = md; id_ex_MulDivOp = mdop;
        id_ex_RegWrite = 1'b1; id_ex_MemRead = 1'b0; id_ex_MemWrite = 1'b0; id_ex_ResultSrc = 2'b00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, ex_busy}, 32'd0);
        chk({tag, "_alu"}, ex_mem_alu_result, 32'd0);
        chk({tag, "_store"}, ex_mem_store_val, 32'd0);
        chk({tag, "_link"}, ex_mem_link_val, 32'd0);
        chk({tag, "_rd"}, {27'd0, ex_mem_rd}, 32'd0);
        chk({tag, "_ctl"}, {27'd0, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite, ex_mem_ResultSrc},
            32'd0);
    endtask

    // Runs one op through ALU/MUL path: result due one edge later, no stall.
    task automatic do_op(input string tag, input logic [3:0] aluc, input logic md,
                         input logic [2:0] mdop, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] exp);
        set_instr(aluc, md, mdop, 5'd0, 5'd0, 5'd7, v1, v2, 32'd0, 1'b0);
        #1;
        chk({tag, "_busy"}, {31'd0, ex_busy}, 32'd0);
        tick();
        chk(tag, ex_mem_alu_result, exp);
    endtask

    task automatic do_div(input string tag, input logic [2:0] mdop, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int busy_cnt   = 0;
        int bubble_cnt = 0;
        set_instr(4'd0, 1'b1, mdop, 5'd0, 5'd0, rd, a, b, 32'd0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!ex_busy) break;
            busy_cnt++;
            tick();
            if (!ex_mem_RegWrite && !ex_mem_MemRead && !ex_mem_MemWrite && ex_mem_rd == 5'd0)
                bubble_cnt++;
        end
        chk({tag, "_busycycles"}, busy_cnt, 32'd33);
        chk({tag, "_bubbles"}, bubble_cnt, 32'd33);
        tick();
        chk(tag, ex_mem_alu_result, exp);
        chk({tag, "_rd"}, {27'd0, ex_mem_rd}, {27'd0, rd});
        chk({tag, "_we"}, {31'd0, ex_mem_RegWrite}, 32'd1);
    endtask

    initial begin
        int late_writes;
        reset_n = 1'b0; flush = 1'b0;
        wb_rd = '0; wb_RegWrite = 1'b0; wb_result = '0;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;

        // x1 = 4+5 lands in EX/MEM
        set_instr(4'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd4, 32'd5, 32'd0, 1'b0);
        tick();
        chk("add_x1", ex_mem_alu_result, 32'd9);
        chk("add_x1_rd", {27'd0, ex_mem_rd}, 32'd1);
        chk("add_x1_link", ex_mem_link_val, cur_pc + 32'd4);

        set_instr(4'd0, 1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0);
        tick();
        chk("fwd_exmem", ex_mem_alu_result, 32'd16);

        wb_RegWrite = 1'b1; wb_rd = 5'd1; wb_result = 32'd20;
        set_instr(4'd0, 1'b0, 3'd0, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, 1'b0);
        tick();
        chk("fwd_memwb", ex_mem_alu_result, 32'd27);

        wb_rd = 5'd4; wb_result = 32'd100;
        set_instr(4'd0, 1'b0, 3'd0, 5'd4, 5'd0, 5'd5, 32'd0, 32'd1, 32'd0, 1'b0);
        tick();
        chk("fwd_priority", ex_mem_alu_result, 32'd28);

        wb_RegWrite = 1'b0;
        set_instr(4'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd5, 32'd7, 32'd0, 1'b0);
        tick();
        chk("add_rd0", ex_mem_alu_result, 32'd12);

        wb_RegWrite = 1'b1; wb_rd = 5'd0; wb_result = 32'd99;
        set_instr(4'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd6, 32'd3, 32'd4, 32'd0, 1'b0);
        tick();
        chk("nofwd_x0", ex_mem_alu_result, 32'd7);

        // SUB x7 = x6 - imm 2 with forwarded x6 = 7; store value is forwarded rs2
        wb_RegWrite = 1'b0;
        set_instr(4'd1, 1'b0, 3'd0, 5'd6, 5'd6, 5'd7, 32'd1, 32'h55, 32'd2, 1'b1);
        tick();
        chk("sub_imm", ex_mem_alu_result, 32'd5);
        chk("store_fwd", ex_mem_store_val, 32'd7);

        do_op("sra", 4'd7, 1'b0, 3'd0, 32'h8000_0000, 32'd4, 32'hF800_0000);
        do_op("srl", 4'd6, 1'b0, 3'd0, 32'h8000_0000, 32'd4, 32'h0800_0000);
        do_op("sll", 4'd5, 1'b0, 3'd0, 32'h0000_0003, 32'd31, 32'h8000_0000);
        do_op("slt", 4'd8, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        do_op("sltu", 4'd9, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        do_op("xor", 4'd4, 1'b0, 3'd0, 32'hF0F0_1234, 32'h0FF0_1200, 32'hFF00_0034);
        do_op("passb", 4'd10, 1'b0, 3'd0, 32'd1, 32'hABCD_0001, 32'hABCD_0001);
        do_op("badop", 4'd11, 1'b0, 3'd0, 32'd5, 32'd6, 32'd0);

        do_op("mulh", 4'd0, 1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        do_op("mulhu", 4'd0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("mul", 4'd0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        do_op("mulhsu", 4'd0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

        do_div("div_m7_2", 3'd4, 5'd8, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_div("rem_m7_2", 3'd6, 5'd8, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_div("divu_by0", 3'd5, 5'd8, 32'd100, 32'd0, 32'hFFFF_FFFF);
        do_div("remu_by0", 3'd7, 5'd8, 32'd100, 32'd0, 32'd100);
        do_div("div_by0", 3'd4, 5'd8, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        do_div("rem_by0", 3'd6, 5'd8, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        do_div("rem_ovf", 3'd6, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_div("div_ovf", 3'd4, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_div("div_20_m3", 3'd4, 5'd8, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA);

        // Flush at BUSY cycle 10
        set_instr(4'd0, 1'b1, 3'd4, 5'd0, 5'd0, 5'd9, 32'd100, 32'd7, 32'd0, 1'b0);
        #1;
        chk("flush_busy_start", {31'd0, ex_busy}, 32'd1);
        repeat (10) tick();
        chk("flush_busy_pre", {31'd0, ex_busy}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_busy_drop", {31'd0, ex_busy}, 32'd0);
        tick();
        chk("flush_bubble", {26'd0, ex_mem_rd, ex_mem_RegWrite}, 32'd0);
        flush = 1'b0;
        set_instr(4'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd10, 32'd2, 32'd3, 32'd0, 1'b0);
        #1;
        chk("post_flush_busy", {31'd0, ex_busy}, 32'd0);
        tick();
        chk("post_flush_add", ex_mem_alu_result, 32'd5);
        chk("post_flush_rd", {27'd0, ex_mem_rd}, 32'd10);

        // Flushed ALU op in IDLE becomes a bubble
        flush = 1'b1;
        set_instr(4'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd11, 32'd2, 32'd3, 32'd0, 1'b0);
        tick();
        chk("flush_idle", {26'd0, ex_mem_rd, ex_mem_RegWrite}, 32'd0);
        flush = 1'b0;

        // An aborted divide must never deliver a late result
        set_nop();
        late_writes = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ex_mem_RegWrite) late_writes++;
        end
        chk("no_late_write", late_writes, 32'd0);

        // Reset during a divide
        set_instr(4'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd12, 32'h70, 32'h7, 32'd0, 1'b0);
        tick();
        chk("pre_reset_add", ex_mem_alu_result, 32'h77);
        set_instr(4'd0, 1'b1, 3'd5, 5'd0, 5'd0, 5'd13, 32'd50, 32'd5, 32'd0, 1'b0);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk_all_zero("reset_mid_div");
        tick();
        reset_n = 1'b1;
        do_div("divu_9_3", 3'd5, 5'd14, 32'd9, 32'd3, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
